// File: rtl/output_framer_if.sv
// output_framer_if: AXI-stream input and output channels of the output framer.
interface output_framer_if #(parameter int OUTW = 24);
  logic [OUTW-1:0] IN_AXIS_TDATA;
  logic            IN_AXIS_TVALID;
  logic            IN_AXIS_TREADY;
  logic [OUTW-1:0] OUT_AXIS_TDATA;
  logic            OUT_AXIS_TVALID;
  logic            OUT_AXIS_TREADY;
  logic            OUT_AXIS_TLAST;
  logic            OUT_AXIS_TUSER;
  modport slave (
    input  IN_AXIS_TDATA, IN_AXIS_TVALID, OUT_AXIS_TREADY,
    output IN_AXIS_TREADY, OUT_AXIS_TDATA, OUT_AXIS_TVALID, OUT_AXIS_TLAST, OUT_AXIS_TUSER
  );
  modport master (
    output IN_AXIS_TDATA, IN_AXIS_TVALID, OUT_AXIS_TREADY,
    input  IN_AXIS_TREADY, OUT_AXIS_TDATA, OUT_AXIS_TVALID, OUT_AXIS_TLAST, OUT_AXIS_TUSER
  );
endinterface

// File: rtl/output_framer.sv
// output_framer: two-entry skid buffer tagging samples with row TLAST / frame TUSER.
// Optional macro FRAMER_RELU_EN clamps negative samples to zero on input.
module output_framer #(
  parameter int OUTW = 24,
  parameter int COLS = 19,
  parameter int ROWS = 19
) (
  input  logic            clk,
  input  logic            reset,
  output_framer_if.slave  s,
  output logic            frame_done
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
  typedef struct packed {
    logic [OUTW-1:0] data;
    logic            last;
    logic            user;
    logic [RW-1:0]   row;
  } entry_t;
  state_t          state_q, state_d;
  entry_t          main_q, skid_q, in_e;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic            in_ready_q, out_valid_q, frame_done_q;
  logic            in_xfer, out_xfer;
  logic [OUTW-1:0] din;
`ifdef FRAMER_RELU_EN
  assign din = s.IN_AXIS_TDATA[OUTW-1] ? '0 : s.IN_AXIS_TDATA;
`else
  assign din = s.IN_AXIS_TDATA;
`endif
  always_comb begin
    in_xfer  = s.IN_AXIS_TVALID && in_ready_q;
    out_xfer = out_valid_q && s.OUT_AXIS_TREADY;
    in_e     = '{data: din, last: col_q == COL_MAX, user: col_q == '0 && row_q == '0, row: row_q};
    state_d  = state_q == EMPTY ? (in_xfer ? BUSY : EMPTY) :
               state_q == BUSY  ? (in_xfer && !out_xfer ? FULL : !in_xfer && out_xfer ? EMPTY : BUSY) :
                                  (out_xfer ? BUSY : FULL);
  end
  // Ready and valid are registered from the next state so neither depends combinationally on downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= state_d != FULL;
      out_valid_q  <= state_d != EMPTY;
      frame_done_q <= out_xfer && main_q.last && main_q.row == ROW_MAX;
      if (in_xfer) begin
        col_q <= col_q == COL_MAX ? '0 : col_q + CW'(1);
        if (col_q == COL_MAX) row_q <= row_q == ROW_MAX ? '0 : row_q + RW'(1);
      end
      if (in_xfer && (state_q == EMPTY || out_xfer)) main_q <= in_e;
      else if (state_q == FULL && out_xfer) main_q <= skid_q;
      if (in_xfer && state_q == BUSY && !out_xfer) skid_q <= in_e;
    end
  end
  assign s.IN_AXIS_TREADY  = in_ready_q;
  assign s.OUT_AXIS_TVALID = out_valid_q;
  assign s.OUT_AXIS_TDATA  = main_q.data;
  assign s.OUT_AXIS_TLAST  = main_q.last;
  assign s.OUT_AXIS_TUSER  = main_q.user;
  assign frame_done        = frame_done_q;
endmodule

// File: tb/tb_output_framer.sv
// tb_output_framer: randomized scenarios checked against a queue-based framing model.
module tb_output_framer;
  localparam int OUTW = 24, COLS = 19, ROWS = 19, FR = COLS * ROWS;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_done;
  output_framer_if #(.OUTW(OUTW)) bus();
  output_framer #(.OUTW(OUTW), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .s(bus), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [23:0] d;
    logic        l;
    logic        u;
    int          row;
  } smp_t;
  smp_t q[$];
  int   acc;
  logic eof_pend;
  int   n_pass = 0, n_chk = 0;
  function automatic logic [23:0] relu(input logic [23:0] x);
`ifdef FRAMER_RELU_EN
    return x[23] ? 24'd0 : x;
`else
    return x;
`endif
  endfunction
  task automatic model_reset();
    q.delete();
    acc = 0;
    eof_pend = 1'b0;
  endtask
  task automatic do_reset();
    bus.IN_AXIS_TVALID = 1'b0;
    bus.IN_AXIS_TDATA = '0;
    bus.OUT_AXIS_TREADY = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
  endtask
  // One clock: drive at the falling edge, observe, update the model, advance to the next falling edge.
  task automatic cycle(input logic v, input logic [23:0] d, input logic r, output logic ix, output logic ox,
                       output smp_t got, output smp_t exp, output logic fd, output logic fd_exp, output logic comb_ok);
    logic ra;
    bus.IN_AXIS_TVALID = v;
    bus.IN_AXIS_TDATA = d;
    bus.OUT_AXIS_TREADY = r;
    #1 ra = bus.IN_AXIS_TREADY;
    bus.OUT_AXIS_TREADY = !r;
    #1 comb_ok = bus.IN_AXIS_TREADY === ra;
    bus.OUT_AXIS_TREADY = r;
    #1 fd = frame_done;
    fd_exp = eof_pend;
    ix = v && bus.IN_AXIS_TREADY;
    ox = bus.OUT_AXIS_TVALID && r;
    got = '{bus.OUT_AXIS_TDATA, bus.OUT_AXIS_TLAST, bus.OUT_AXIS_TUSER, 0};
    exp = '{24'hBADBAD, 1'b0, 1'b0, -1};
    if (ox && q.size() > 0) exp = q.pop_front();
    eof_pend = ox && exp.l && exp.row == ROWS - 1;
    if (ix) begin
      q.push_back('{relu(d), acc % COLS == COLS - 1, acc % FR == 0, (acc / COLS) % ROWS});
      acc++;
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    bus.IN_AXIS_TVALID = 1'b0;
    bus.IN_AXIS_TDATA = '0;
    bus.OUT_AXIS_TREADY = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (bus.IN_AXIS_TREADY !== 1'b0) $display("FAIL rst_ready got %b exp 0", bus.IN_AXIS_TREADY); else n_pass++;
    n_chk++; if (bus.OUT_AXIS_TVALID !== 1'b0) $display("FAIL rst_valid got %b exp 0", bus.OUT_AXIS_TVALID); else n_pass++;
    n_chk++; if (bus.OUT_AXIS_TLAST !== 1'b0) $display("FAIL rst_last got %b exp 0", bus.OUT_AXIS_TLAST); else n_pass++;
    n_chk++; if (bus.OUT_AXIS_TUSER !== 1'b0) $display("FAIL rst_user got %b exp 0", bus.OUT_AXIS_TUSER); else n_pass++;
    n_chk++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done got %b exp 0", frame_done); else n_pass++;
    n_chk++; if (bus.OUT_AXIS_TDATA !== 24'd0) $display("FAIL rst_data got %h exp 000000", bus.OUT_AXIS_TDATA); else n_pass++;
    reset = 1'b1;
    model_reset();
    #1;
    n_chk++; if (bus.IN_AXIS_TREADY !== 1'b0) $display("FAIL release_ready_early got %b exp 0", bus.IN_AXIS_TREADY); else n_pass++;
    @(negedge clk);
    n_chk++; if (bus.IN_AXIS_TREADY !== 1'b1) $display("FAIL release_ready_rise got %b exp 1", bus.IN_AXIS_TREADY); else n_pass++;
  endtask
  task automatic test_stream();
    logic ix, ox, fd, fde, cok;
    smp_t got, exp;
    int n_out = 0, n_fd = 0;
    do_reset();
    for (int i = 0; i < FR + 5; i++) begin
      cycle(i < FR, 24'($urandom), 1'b1, ix, ox, got, exp, fd, fde, cok);
      n_fd += int'(fd);
      if (ox) begin
        n_chk++; if (got.d !== exp.d) $display("FAIL stream_data[%0d] got %h exp %h", n_out, got.d, exp.d); else n_pass++;
        n_chk++; if (got.l !== (n_out % COLS == COLS - 1)) $display("FAIL stream_last[%0d] got %b", n_out, got.l); else n_pass++;
        n_chk++; if (got.u !== (n_out == 0)) $display("FAIL stream_user[%0d] got %b", n_out, got.u); else n_pass++;
        n_out++;
      end
    end
    n_chk++; if (n_out != FR) $display("FAIL stream_count got %0d exp %0d", n_out, FR); else n_pass++;
    n_chk++; if (n_fd != 1) $display("FAIL stream_frame_done got %0d pulses exp 1", n_fd); else n_pass++;
  endtask
  task automatic test_backpressure();
    logic ix, ox, fd, fde, cok;
    smp_t got, exp;
    logic [23:0] vals [3];
    int n_out = 0;
    do_reset();
    foreach (vals[i]) vals[i] = 24'($urandom);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, vals[i], 1'b0, ix, ox, got, exp, fd, fde, cok);
      n_chk++; if (ix !== (i < 2)) $display("FAIL bp_accept[%0d] got %b exp %b", i, ix, i < 2); else n_pass++;
      n_chk++; if (bus.IN_AXIS_TREADY !== (i == 0)) $display("FAIL bp_ready[%0d] got %b exp %b", i, bus.IN_AXIS_TREADY, i == 0); else n_pass++;
      n_chk++; if (bus.OUT_AXIS_TVALID !== 1'b1 || bus.OUT_AXIS_TDATA !== vals[0])
        $display("FAIL bp_hold[%0d] got %b/%h exp 1/%h", i, bus.OUT_AXIS_TVALID, bus.OUT_AXIS_TDATA, vals[0]); else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 24'd0, 1'b1, ix, ox, got, exp, fd, fde, cok);
      if (ox) begin
        n_chk++; if (got.d !== vals[n_out]) $display("FAIL bp_drain[%0d] got %h exp %h", n_out, got.d, vals[n_out]); else n_pass++;
        n_out++;
      end
    end
    n_chk++; if (n_out != 2) $display("FAIL bp_count got %0d exp 2", n_out); else n_pass++;
  endtask
  task automatic test_random();
    logic ix, ox, fd, fde, cok, v, r;
    smp_t got, exp;
    int n_fd = 0, c = 0;
    do_reset();
    for (c = 0; c < 20000 && (acc < 2 * FR || q.size() > 0 || eof_pend); c++) begin
      v = acc < 2 * FR ? 1'($urandom) : 1'b0;
      r = acc < 2 * FR ? 1'($urandom) : 1'b1;
      cycle(v, 24'($urandom), r, ix, ox, got, exp, fd, fde, cok);
      n_fd += int'(fd);
      n_chk++; if (!cok) $display("FAIL rnd_comb_ready cycle %0d ready followed OUT_AXIS_TREADY", c); else n_pass++;
      n_chk++; if (fd !== fde) $display("FAIL rnd_frame_done cycle %0d got %b exp %b", c, fd, fde); else n_pass++;
      if (ox) begin
        n_chk++; if (got.d !== exp.d || got.l !== exp.l || got.u !== exp.u)
          $display("FAIL rnd_sample cycle %0d got %h/%b/%b exp %h/%b/%b", c, got.d, got.l, got.u, exp.d, exp.l, exp.u); else n_pass++;
      end
    end
    n_chk++; if (acc != 2 * FR || q.size() != 0) $display("FAIL rnd_timeout accepted %0d left %0d exp %0d/0", acc, q.size(), 2 * FR); else n_pass++;
    n_chk++; if (n_fd != 2) $display("FAIL rnd_frame_count got %0d exp 2", n_fd); else n_pass++;
  endtask
  task automatic test_reset_mid();
    logic ix, ox, fd, fde, cok;
    smp_t got, exp;
    logic [23:0] d0;
    int n_out = 0;
    do_reset();
    for (int c = 0; c < 1000 && acc < 100; c++) cycle(1'b1, 24'($urandom), 1'($urandom), ix, ox, got, exp, fd, fde, cok);
    n_chk++; if (acc != 100) $display("FAIL mid_prefill got %0d exp 100", acc); else n_pass++;
    reset = 1'b0;
    #1;
    n_chk++; if (bus.OUT_AXIS_TVALID !== 1'b0 || bus.OUT_AXIS_TDATA !== 24'd0)
      $display("FAIL mid_async_clear got %b/%h exp 0/000000", bus.OUT_AXIS_TVALID, bus.OUT_AXIS_TDATA); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    d0 = 24'($urandom);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, i == 0 ? d0 : 24'($urandom), 1'b1, ix, ox, got, exp, fd, fde, cok);
      if (ox) begin
        if (n_out == 0) begin
          n_chk++; if (got.u !== 1'b1 || got.d !== relu(d0)) $display("FAIL mid_first got %h/%b exp %h/1", got.d, got.u, relu(d0)); else n_pass++;
        end else begin
          n_chk++; if (got.d !== exp.d || got.u !== 1'b0 || got.l !== 1'b0) $display("FAIL mid_next[%0d] got %h/%b/%b exp %h/0/0", n_out, got.d, got.u, got.l, exp.d); else n_pass++;
        end
        n_out++;
      end
    end
    n_chk++; if (n_out < 1) $display("FAIL mid_no_output got 0 outputs"); else n_pass++;
  endtask
  task automatic test_relu();
    logic ix, ox, fd, fde, cok;
    smp_t got, exp;
    logic [23:0] want [2];
    int n_out = 0;
`ifdef FRAMER_RELU_EN
    want = '{24'h000000, 24'h00000A};
`else
    want = '{24'hFFFFF6, 24'h00000A};
`endif
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(i < 2, i == 0 ? 24'hFFFFF6 : 24'h00000A, 1'b1, ix, ox, got, exp, fd, fde, cok);
      if (ox && n_out < 2) begin
        n_chk++; if (got.d !== want[n_out]) $display("FAIL relu[%0d] got %h exp %h", n_out, got.d, want[n_out]); else n_pass++;
        n_out++;
      end
    end
    n_chk++; if (n_out != 2) $display("FAIL relu_count got %0d exp 2", n_out); else n_pass++;
  endtask
  initial begin
    bus.IN_AXIS_TVALID = 1'b0;
    bus.IN_AXIS_TDATA = '0;
    bus.OUT_AXIS_TREADY = 1'b0;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_relu();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
